ysyx_25060170_lsu: RTL
======================

YSYX_25060170_LSU -- requirements
Module: ysyx_25060170_lsu

Interface
REQ-001 SHALL have port clk, in, 1: single clock, all state updates on rising edge.
REQ-002 SHALL have port rst, in, 1: reset, synchronous, active-high.
REQ-003 SHALL have port ready_i, in, 1: execute-stage result valid, a one-cycle pulse.
REQ-004 SHALL have port addr_i, in, 32: ALU result, used as the effective address.
REQ-005 SHALL have port wdata_i, in, 32: store data (rs2).
REQ-006 SHALL have ports mem_ren, in, 1 (load) and mem_wen, in, 1 (store).
REQ-007 SHALL have port funct3, in, 3: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-008 SHALL have ports mreq_valid out 1, mreq_ready in 1, mreq_wen out 1, mreq_addr out 32, mreq_wdata out 32, mreq_wmask out 4.
REQ-009 SHALL have ports mrsp_valid in 1 and mrsp_rdata in 32: memory response.
REQ-010 SHALL have ports res_o out 32, ready_o out 1 (one-cycle pulse), misalign_o out 1, busy_o out 1.

Function
REQ-011 SHALL use FSM states IDLE, REQ, WAIT, RESP; busy_o SHALL be 1 in every state except IDLE.
REQ-012 In IDLE with ready_i=1, inputs SHALL be latched; ready_i in any other state SHALL be ignored.
REQ-013 With mem_ren=0 and mem_wen=0, the FSM SHALL go to RESP with res_o=addr_i, so ready_o rises exactly 1 cycle after ready_i.
REQ-014 When mem_ren=1 and mem_wen=1 are both set, the access SHALL be a load and mem_wen SHALL be ignored.
REQ-015 A misaligned access SHALL issue no memory request and SHALL go to RESP with res_o=0 and misalign_o=1 (pulse, coincident with ready_o).
- Halfword: addr[0]=1.
- Word: addr[1:0]!=0.
REQ-016 An aligned access SHALL go to REQ, with mreq_addr={addr[31:2],2'b00} and mreq_wen=store.
REQ-017 In REQ, mreq_valid SHALL be 1, with addr/wen/wdata/wmask held stable until the cycle mreq_ready=1; the FSM SHALL then go to WAIT.
REQ-018 Store mask SHALL be:
- Byte: 4'b0001<<addr[1:0].
- Halfword: 4'b0011<<{addr[1],1'b0}.
- Word: 4'b1111.
- Loads: 4'b0000.
REQ-019 Store data SHALL be:
- Byte: replicated {4{wdata[7:0]}}.
- Halfword: replicated {2{wdata[15:0]}}.
- Word: as-is.
REQ-020 In WAIT, mrsp_valid=1 SHALL move the FSM to RESP; mrsp_valid in any other state SHALL be ignored. Stores also wait for a response.
REQ-021 Load data SHALL be sh=mrsp_rdata>>(8*addr[1:0]), then extended:
- b: sign-extend sh[7:0].
- bu: zero-extend sh[7:0].
- h: sign-extend sh[15:0].
- hu: zero-extend sh[15:0].
- w: sh.
REQ-022 A store SHALL return res_o=0.
REQ-023 In RESP, ready_o SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-024 res_o SHALL hold its value until the next RESP.
REQ-025 Minimum aligned-access latency (mreq_ready=1 in REQ, mrsp_valid=1 in the first WAIT cycle) SHALL be 3 cycles from ready_i to ready_o.
REQ-026 funct3 values 011, 110 and 111 SHALL be treated as w.

Reset
REQ-027 While rst=1 at a clock edge, the FSM SHALL go to IDLE, and all of the following SHALL be 0 on the next cycle:
- res_o, ready_o, misalign_o, busy_o, mreq_valid, mreq_wen, mreq_addr, mreq_wdata, mreq_wmask.
REQ-028 Reset during REQ or WAIT SHALL abort the access with no ready_o pulse; a late mrsp_valid after reset SHALL be ignored.
REQ-029 ready_i asserted in the same cycle as rst=1 SHALL be dropped.

Verification
REQ-030 Bench SHALL drive pass-through: ready_i with ren=wen=0, addr_i=0x1234 -> next cycle ready_o=1, res_o=0x1234, busy_o=0 after.
REQ-031 Bench SHALL drive lb at addr 0x8000_0003 with rdata 0x80FF_FF7F -> mreq_addr=0x8000_0000, wmask=0; res_o=0xFFFF_FF80.
- Same access as lbu -> 0x0000_0080.
REQ-032 Bench SHALL drive sh at 0x8000_0002 with wdata 0xDEAD_BEEF -> mreq_wdata=0xBEEF_BEEF, wmask=4'b1100, mreq_wen=1.
- mreq_ready held 0 for 3 cycles: mreq_* stay stable throughout.
REQ-033 Bench SHALL drive lw at 0x8000_0002 -> no mreq_valid; next cycle ready_o=1, misalign_o=1, res_o=0.
REQ-034 Bench SHALL assert rst while in WAIT, then drive mrsp_valid=1 one cycle later -> mreq_valid=0, no ready_o pulse, state IDLE.
REQ-035 Bench SHALL drive a second ready_i while busy_o=1 -> it is ignored: exactly one ready_o pulse, with the first access's result.

Source files
------------

// File: rtl/ysyx_25060170_lsu.sv
// Load/store unit: takes one execute-stage result, issues at most one memory
// request, and returns the aligned/extended load data (or pass-through value).
module ysyx_25060170_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        ready_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [2:0]  funct3,
    output logic        mreq_valid,
    input  logic        mreq_ready,
    output logic        mreq_wen,
    output logic [31:0] mreq_addr,
    output logic [31:0] mreq_wdata,
    output logic [3:0]  mreq_wmask,
    input  logic        mrsp_valid,
    input  logic [31:0] mrsp_rdata,
    output logic [31:0] res_o,
    output logic        ready_o,
    output logic        misalign_o,
    output logic        busy_o,
    output logic [1:0]  state_o
);

    // Handshake: a request transfers on the cycle mreq_valid && mreq_ready;
    // mreq_* are held stable until then. mrsp_valid is only honoured in WAIT.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t state, state_n;

    logic        size_b, size_h, size_w;
    logic        mem_acc, is_store, misalign;
    logic [3:0]  st_mask;
    logic [31:0] st_data;

    logic [1:0]  off_q;
    logic        size_b_q, size_h_q, unsigned_q, store_q, misalign_q;
    logic [31:0] sh;
    logic [31:0] ld_data;

    // Decode of the incoming execute-stage result (only meaningful in IDLE).
    always_comb begin
        size_b   = (funct3[1:0] == 2'b00);
        size_h   = (funct3[1:0] == 2'b01);
        size_w   = !size_b && !size_h;
        mem_acc  = mem_ren || mem_wen;
        is_store = !mem_ren && mem_wen;
        misalign = mem_acc && ((size_h && addr_i[0]) || (size_w && (addr_i[1:0] != 2'b00)));
        st_mask  = 4'b1111;
        st_data  = wdata_i;
        if (size_b) begin
            st_mask = 4'b0001 << addr_i[1:0];
            st_data = {4{wdata_i[7:0]}};
        end else if (size_h) begin
            st_mask = 4'b0011 << {addr_i[1], 1'b0};
            st_data = {2{wdata_i[15:0]}};
        end
    end

    always_comb begin
        sh      = mrsp_rdata >> {off_q, 3'b000};
        ld_data = sh;
        if (size_b_q) begin
            ld_data = unsigned_q ? {24'b0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
        end else if (size_h_q) begin
            ld_data = unsigned_q ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (ready_i) state_n = (!mem_acc || misalign) ? S_RESP : S_REQ;
            S_REQ:  if (mreq_ready) state_n = S_WAIT;
            S_WAIT: if (mrsp_valid) state_n = S_RESP;
            S_RESP: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            off_q      <= 2'b0;
            size_b_q   <= 1'b0;
            size_h_q   <= 1'b0;
            unsigned_q <= 1'b0;
            store_q    <= 1'b0;
            misalign_q <= 1'b0;
            res_o      <= 32'b0;
            mreq_wen   <= 1'b0;
            mreq_addr  <= 32'b0;
            mreq_wdata <= 32'b0;
            mreq_wmask <= 4'b0;
        end else begin
            if (state == S_IDLE && ready_i) begin
                off_q      <= addr_i[1:0];
                size_b_q   <= size_b;
                size_h_q   <= size_h;
                unsigned_q <= funct3[2];
                store_q    <= is_store;
                misalign_q <= misalign;
                if (!mem_acc) begin
                    res_o <= addr_i;
                end else if (misalign) begin
                    res_o <= 32'b0;
                end else begin
                    mreq_addr  <= {addr_i[31:2], 2'b00};
                    mreq_wen   <= is_store;
                    mreq_wdata <= is_store ? st_data : 32'b0;
                    mreq_wmask <= is_store ? st_mask : 4'b0;
                end
            end
            // Stores complete on the response too, but always report zero.
            if (state == S_WAIT && mrsp_valid) begin
                res_o <= store_q ? 32'b0 : ld_data;
            end
        end
    end

    assign mreq_valid = (state == S_REQ);
    assign ready_o    = (state == S_RESP);
    assign misalign_o = (state == S_RESP) && misalign_q;
    assign busy_o     = (state != S_IDLE);
    assign state_o    = state;

endmodule
